// File: rtl/skintone_pkg.sv
// Shared constants and packer state type for the skintone pixel packer.
// Pixel width, lane count and keep width are fixed here for every file of the block.
package skintone_pkg;

    localparam int C_PIXEL_WIDTH = 32;
    localparam int C_LANES       = 4;
    localparam int C_KEEP_W      = C_LANES;
    localparam int C_LANE_IDX_W  = 2;

    typedef enum logic {
        EMPTY   = 1'b0,
        PARTIAL = 1'b1
    } packer_state_e;

endpackage

// File: rtl/skintone_out_reg.sv
// Single-entry valid/ready output register carrying a packed word with keep and last.
// A load always wins; it is only requested when the slot is empty or draining this edge.
module skintone_out_reg
    import skintone_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic [C_DATA_WIDTH-1:0] i_data,
    input  logic [C_KEEP_W-1:0]     i_keep,
    input  logic                    i_last,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [C_DATA_WIDTH-1:0] o_data,
    output logic [C_KEEP_W-1:0]     o_keep,
    output logic                    o_last
);

    logic                    r_valid;
    logic [C_DATA_WIDTH-1:0] r_data;
    logic [C_KEEP_W-1:0]     r_keep;
    logic                    r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule

// File: rtl/skintone_pixel_packer.sv
// Packs 32-bit pixels into 128-bit words (lane 0 first) with keep/last framing.
// Optional macro SKINTONE_PACKER_CNT_EN adds pixel_count and frame_count outputs.
module skintone_pixel_packer
    import skintone_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 128,
    parameter int C_PIXEL_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [C_PIXEL_WIDTH-1:0] pixel_in,
    input  logic                     pixel_in_valid,
    input  logic                     pixel_in_last,
    output logic                     pixel_in_ready,
    output logic [C_DATA_WIDTH-1:0]  pixel_datain,
    output logic                     pixel_datain_valid,
    input  logic                     pixel_datain_ready,
    output logic [C_KEEP_W-1:0]      pixel_datain_keep,
    output logic                     pixel_datain_last
`ifdef SKINTONE_PACKER_CNT_EN
    ,
    output logic [31:0]              pixel_count,
    output logic [15:0]              frame_count
`endif
);

    packer_state_e           r_state;
    logic [C_LANE_IDX_W-1:0] r_lane;
    logic [C_DATA_WIDTH-1:0] r_acc;
    logic [C_KEEP_W-1:0]     r_keep;

    logic                    w_in_ready;
    logic                    w_in_xfer;
    logic                    w_complete;
    logic [C_DATA_WIDTH-1:0] w_acc_next;
    logic [C_KEEP_W-1:0]     w_keep_next;
    logic                    w_out_valid;

    // Output slot is free when empty or being drained on this edge.
    assign w_in_ready = !w_out_valid || pixel_datain_ready;
    assign w_in_xfer  = pixel_in_valid && w_in_ready;
    assign w_complete = w_in_xfer && ((r_lane == C_LANE_IDX_W'(C_LANES - 1)) || pixel_in_last);

    always_comb begin
        w_acc_next  = (r_state == EMPTY) ? '0 : r_acc;
        w_keep_next = (r_state == EMPTY) ? '0 : r_keep;
        w_acc_next[r_lane*C_PIXEL_WIDTH +: C_PIXEL_WIDTH] = pixel_in;
        w_keep_next[r_lane] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_lane  <= '0;
            r_acc   <= '0;
            r_keep  <= '0;
        end else if (w_in_xfer) begin
            if (w_complete) begin
                r_state <= EMPTY;
                r_lane  <= '0;
                r_acc   <= '0;
                r_keep  <= '0;
            end else begin
                r_state <= PARTIAL;
                r_lane  <= r_lane + 1'b1;
                r_acc   <= w_acc_next;
                r_keep  <= w_keep_next;
            end
        end
    end

    skintone_out_reg #(
        .C_DATA_WIDTH (C_DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_complete),
        .i_data  (w_acc_next),
        .i_keep  (w_keep_next),
        .i_last  (pixel_in_last),
        .i_ready (pixel_datain_ready),
        .o_valid (w_out_valid),
        .o_data  (pixel_datain),
        .o_keep  (pixel_datain_keep),
        .o_last  (pixel_datain_last)
    );

    assign pixel_in_ready     = w_in_ready;
    assign pixel_datain_valid = w_out_valid;

`ifdef SKINTONE_PACKER_CNT_EN
    logic [31:0] r_pixel_count;
    logic [15:0] r_frame_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel_count <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_in_xfer) begin
                r_pixel_count <= r_pixel_count + 32'd1;
            end
            if (w_out_valid && pixel_datain_ready && pixel_datain_last) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign pixel_count = r_pixel_count;
    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_skintone_pixel_packer.sv
// Self-checking bench for skintone_pixel_packer: directed cases plus randomized traffic
// scored against a word-grouping reference model (counters checked when SKINTONE_PACKER_CNT_EN is set).
module tb_skintone_pixel_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  pixel_in = '0;
    logic         pixel_in_valid = 1'b0;
    logic         pixel_in_last = 1'b0;
    logic         pixel_in_ready;
    logic [127:0] pixel_datain;
    logic         pixel_datain_valid;
    logic         pixel_datain_ready = 1'b0;
    logic [3:0]   pixel_datain_keep;
    logic         pixel_datain_last;
`ifdef SKINTONE_PACKER_CNT_EN
    logic [31:0]  pixel_count;
    logic [15:0]  frame_count;
`endif

    skintone_pixel_packer #(
        .C_DATA_WIDTH  (128),
        .C_PIXEL_WIDTH (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pixel_in           (pixel_in),
        .pixel_in_valid     (pixel_in_valid),
        .pixel_in_last      (pixel_in_last),
        .pixel_in_ready     (pixel_in_ready),
        .pixel_datain       (pixel_datain),
        .pixel_datain_valid (pixel_datain_valid),
        .pixel_datain_ready (pixel_datain_ready),
        .pixel_datain_keep  (pixel_datain_keep),
        .pixel_datain_last  (pixel_datain_last)
`ifdef SKINTONE_PACKER_CNT_EN
        ,
        .pixel_count        (pixel_count),
        .frame_count        (frame_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   k;
        logic         l;
    } word_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] pend[$];
    word_t       expq[$];
    logic        prev_hold = 1'b0;
    logic [127:0] prev_d;
    logic [3:0]  prev_k;
    logic        prev_l;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: pixels group into words of up to four, closed early by last.
    task automatic model_accept(input logic [31:0] d, input logic l);
        word_t w;
        int    n;
        pend.push_back(d);
        if (pend.size() == 4 || l) begin
            n   = pend.size();
            w.d = '0;
            for (int i = 0; i < n; i++) w.d[i*32 +: 32] = pend[i];
            w.k = 4'((1 << n) - 1);
            w.l = l;
            expq.push_back(w);
            pend.delete();
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic r,
                         output logic accepted);
        logic in_x;
        logic out_x;
        word_t w;
        @(negedge clk);
        pixel_in_valid     = v;
        pixel_in           = d;
        pixel_in_last      = l;
        pixel_datain_ready = r;
        #1;
        chk("in_ready_rule", 128'(pixel_in_ready), 128'(!pixel_datain_valid || r));
        chk("out_valid", 128'(pixel_datain_valid), 128'(expq.size() != 0));
        if (prev_hold) begin
            chk("hold_data", pixel_datain, prev_d);
            chk("hold_keep", 128'(pixel_datain_keep), 128'(prev_k));
            chk("hold_last", 128'(pixel_datain_last), 128'(prev_l));
        end
        in_x  = v && pixel_in_ready;
        out_x = pixel_datain_valid && r;
        if (out_x) begin
            if (expq.size() == 0) begin
                chk("unexpected_word", 128'(1), 128'(0));
            end else begin
                w = expq.pop_front();
                chk("word_data", pixel_datain, w.d);
                chk("word_keep", 128'(pixel_datain_keep), 128'(w.k));
                chk("word_last", 128'(pixel_datain_last), 128'(w.l));
            end
        end
        prev_hold = pixel_datain_valid && !r;
        prev_d    = pixel_datain;
        prev_k    = pixel_datain_keep;
        prev_l    = pixel_datain_last;
        if (in_x) model_accept(d, l);
        accepted = in_x;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                = 1'b1;
        pixel_in_valid     = 1'b0;
        pixel_in_last      = 1'b0;
        pixel_datain_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_valid", 128'(pixel_datain_valid), 128'(0));
        chk("rst_data", pixel_datain, 128'(0));
        chk("rst_keep", 128'(pixel_datain_keep), 128'(0));
        chk("rst_last", 128'(pixel_datain_last), 128'(0));
        rst = 1'b0;
        pend.delete();
        expq.delete();
        prev_hold = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 128'(pixel_in_ready), 128'(1));
    endtask

    initial begin
        logic acc;
        int   sent;
        int   stall;
        int   guard;

        do_reset();

        // Four full-lane pixels
        cycle(1, 32'h11111111, 0, 1, acc);
        cycle(1, 32'h22222222, 0, 1, acc);
        cycle(1, 32'h33333333, 0, 1, acc);
        cycle(1, 32'h44444444, 0, 1, acc);
        @(posedge clk);
        #1;
        chk("full_word_data", pixel_datain, 128'h44444444_33333333_22222222_11111111);
        chk("full_word_keep", 128'(pixel_datain_keep), 128'(4'hF));
        chk("full_word_last", 128'(pixel_datain_last), 128'(0));
        chk("full_word_valid", 128'(pixel_datain_valid), 128'(1));

        // Two pixels closed by last
        cycle(1, 32'hAAAA0001, 0, 1, acc);
        cycle(1, 32'hAAAA0002, 1, 1, acc);
        @(posedge clk);
        #1;
        chk("part_word_data", pixel_datain, 128'h00000000_00000000_AAAA0002_AAAA0001);
        chk("part_word_keep", 128'(pixel_datain_keep), 128'(4'b0011));
        chk("part_word_last", 128'(pixel_datain_last), 128'(1));

        // Single last pixel from EMPTY
        cycle(1, 32'hBEEF0001, 1, 1, acc);
        @(posedge clk);
        #1;
        chk("single_word_data", pixel_datain, 128'h00000000_00000000_00000000_BEEF0001);
        chk("single_word_keep", 128'(pixel_datain_keep), 128'(4'b0001));
        chk("single_word_last", 128'(pixel_datain_last), 128'(1));
        cycle(0, 0, 0, 1, acc);
        cycle(0, 0, 0, 1, acc);
        chk("idle_empty", 128'(expq.size()), 128'(0));

        // Twelve back-to-back pixels with a 5-cycle stall after the first word
        sent  = 0;
        stall = -1;
        guard = 0;
        while (sent < 12 && guard < 100) begin
            if (sent == 4 && stall < 0) stall = 5;
            if (stall > 0) begin
                cycle(1, 32'h100 + sent, 0, 0, acc);
                stall--;
            end else begin
                cycle(1, 32'h100 + sent, 0, 1, acc);
            end
            if (acc) sent++;
            guard++;
        end
        chk("stall_all_sent", 128'(sent), 128'(12));
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, acc);
        chk("stall_drained", 128'(expq.size()), 128'(0));

        // Reset mid-word discards the partial accumulator
        cycle(1, 32'hDEAD0001, 0, 1, acc);
        cycle(1, 32'hDEAD0002, 0, 1, acc);
        do_reset();
        cycle(1, 32'h5, 0, 1, acc);
        cycle(1, 32'h6, 0, 1, acc);
        cycle(1, 32'h7, 0, 1, acc);
        cycle(1, 32'h8, 0, 1, acc);
        @(posedge clk);
        #1;
        chk("post_rst_word", pixel_datain, 128'h00000008_00000007_00000006_00000005);
        chk("post_rst_keep", 128'(pixel_datain_keep), 128'(4'hF));
        cycle(0, 0, 0, 1, acc);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0, acc);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, acc);
        chk("random_drained", 128'(expq.size()), 128'(0));
        chk("random_valid_low", 128'(pixel_datain_valid), 128'(0));

`ifdef SKINTONE_PACKER_CNT_EN
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 6; p++) cycle(1, 32'h900 + f*6 + p, p == 5, 1, acc);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, acc);
        @(posedge clk);
        #1;
        chk("pixel_count", 128'(pixel_count), 128'(12));
        chk("frame_count", 128'(frame_count), 128'(2));
        chk("cnt_drained", 128'(expq.size()), 128'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/skintone_pixel_packer.md
SKINTONE_PIXEL_PACKER -- requirements
Module: skintone_pixel_packer

Interface
REQ-001 The block SHALL have parameter C_DATA_WIDTH, default 128, the packed output word width.
REQ-002 The block SHALL have parameter C_PIXEL_WIDTH, default 32, the input pixel width; C_DATA_WIDTH/C_PIXEL_WIDTH = 4 lanes.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port pixel_in, input, C_PIXEL_WIDTH, the pixel from the frame source.
REQ-006 The block SHALL have port pixel_in_valid, input, 1, pixel_in is valid.
REQ-007 The block SHALL have port pixel_in_last, input, 1, pixel_in is the last pixel of the frame.
REQ-008 The block SHALL have port pixel_in_ready, output, 1, the packer accepts pixel_in.
REQ-009 The block SHALL have port pixel_datain, output, C_DATA_WIDTH, the packed word to the skintone datapath.
REQ-010 The block SHALL have port pixel_datain_valid, output, 1, pixel_datain is valid.
REQ-011 The block SHALL have port pixel_datain_ready, input, 1, the datapath accepts the word.
REQ-012 The block SHALL have port pixel_datain_keep, output, 4, the per-lane valid mask of the word.
REQ-013 The block SHALL have port pixel_datain_last, output, 1, the word closes the frame.

Function
REQ-014 An input transfer SHALL occur on a rising clk edge when pixel_in_valid and pixel_in_ready are both 1; an output transfer SHALL occur when pixel_datain_valid and pixel_datain_ready are both 1.
REQ-015 pixel_in_ready SHALL equal (!pixel_datain_valid || pixel_datain_ready) and SHALL be combinational from those signals only.
REQ-016 Accepted pixels SHALL fill lanes in order: lane 0 = bits [31:0], then lane 1 = [63:32], lane 2 = [95:64], lane 3 = [127:96]. A 2-bit lane index SHALL wrap from 3 to 0.
REQ-017 The state machine SHALL have two states: EMPTY (lane index 0, accumulator holds nothing) and PARTIAL (1-3 lanes held).
REQ-018 Accepting a pixel in lane 3, or any pixel with pixel_in_last=1, SHALL complete the word. The word SHALL load into the output register on that same edge, and the FSM SHALL return to EMPTY.
REQ-019 A completed word SHALL be valid on the cycle after the completing pixel is accepted (1-cycle latency). Sustained throughput SHALL be 1 pixel per cycle while pixel_datain_ready=1.
REQ-020 On a last-terminated partial word, unused upper lanes SHALL be 0, keep SHALL mark only the filled lanes (e.g. 2 pixels -> 4'b0011), and pixel_datain_last SHALL be 1.
REQ-021 A full word SHALL have keep=4'b1111. pixel_datain_last SHALL equal the pixel_in_last of its lane-3 pixel.
REQ-022 The output register SHALL hold data, keep and last stable while valid=1 and ready=0.
REQ-023 When an output transfer and a new word load occur on the same edge, the new word SHALL replace the old one with valid remaining 1 and no bubble.
REQ-024 pixel_in_last=1 while in EMPTY SHALL produce keep=4'b0001 and last=1.

Reset
REQ-025 While rst=1 on a clk edge, the FSM SHALL enter EMPTY, the lane index SHALL clear to 0, and pixel_datain_valid, pixel_datain, pixel_datain_keep and pixel_datain_last SHALL clear to 0.
REQ-026 Reset mid-word SHALL discard any partially filled accumulator and any un-transferred output word.
REQ-027 pixel_in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 With SKINTONE_PACKER_CNT_EN defined, the block SHALL add output ports pixel_count (32 bits, +1 per input transfer) and frame_count (16 bits, +1 per output transfer with last=1). Both counters SHALL wrap to 0 and clear on rst.
REQ-029 Without SKINTONE_PACKER_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package skintone_pkg SHALL hold C_PIXEL_WIDTH, the lane count (4), the keep width, and the packer state enum (EMPTY, PARTIAL).
REQ-031 The output register SHALL be a sub-module skintone_out_reg: a single-entry valid/ready register carrying data, keep and last.

Verification
REQ-032 Pixels 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles with ready=1 -> one word 0x44444444_33333333_22222222_11111111, keep=4'hF, last=0, valid 1 cycle after the 4th pixel.
REQ-033 Pixels 0xAAAA0001 and 0xAAAA0002 with last=1 on the second -> word 0x0..0_AAAA0002_AAAA0001, keep=4'b0011, last=1; FSM returns to EMPTY.
REQ-034 12 back-to-back pixels with pixel_datain_ready held at 0 for 5 cycles after the first word -> pixel_in_ready=0 and the word held stable during the stall; all 3 words are emitted in order with no loss or duplication.
REQ-035 rst asserted after 2 of 4 pixels, then pixels 0x5, 0x6, 0x7, 0x8 -> the first emitted word is 0x8_7_6_5 (lanes 3..0); the pre-reset pixels are never emitted.
REQ-036 With SKINTONE_PACKER_CNT_EN defined, 2 frames of 6 pixels -> pixel_count=12, frame_count=2, and each frame ends with keep=4'b0011, last=1.
